// File: rtl/counter_pkg.sv
// Shared types and limits for the programmable counter and its receive-side stream checker.
package counter_pkg;

  localparam int unsigned CNT_WIDTH = 8;

  typedef logic [CNT_WIDTH-1:0] cnt_width_t;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2,
    FAULT    = 2'd3
  } chk_state_t;

  localparam cnt_width_t ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/sat_counter.sv
// Registered up-counter with clear and saturation; clear combined with increment yields one.
module sat_counter #(
  parameter int unsigned    W   = 8,
  parameter logic [W-1:0]   MAX = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;
  logic [W-1:0] count_n_s;

  // next count: clear wins over hold, increment stops at MAX
  always_comb begin
    count_n_s = count_r;
    if (clr) begin
      count_n_s = inc ? W'(1) : {W{1'b0}};
    end else if (inc && (count_r != MAX)) begin
      count_n_s = count_r + W'(1);
    end else begin
      count_n_s = count_r;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {W{1'b0}};
    end else begin
      count_r <= count_n_s;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/count_stream_checker.sv
// Monitors a counter bus on sample strobes, locks onto a +1 sequence and tallies breaks in it.
module count_stream_checker
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LOCK_CNT   = 4,
  parameter bit          ALLOW_HOLD = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             sample_en,
  input  logic             resync,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [7:0]       err_count,
  output logic [WIDTH-1:0] last_val
);

  localparam int unsigned MW = $clog2(LOCK_CNT + 1);

  chk_state_t       state_r;
  chk_state_t       state_n_s;
  logic [MW-1:0]    match_cnt_r;
  logic [MW-1:0]    match_cnt_n_s;
  logic [WIDTH-1:0] prev_r;
  logic [WIDTH-1:0] last_val_r;
  logic [WIDTH-1:0] next_exp_s;
  logic             locked_r;
  logic             err_pulse_r;
  logic             match_s;
  logic             hold_s;
  logic             fault_s;
  logic             capture_s;

  // step classification against the previous sample; the sum wraps at 2^WIDTH
  always_comb begin
    next_exp_s = prev_r + WIDTH'(1);
    match_s    = (bus_in == next_exp_s);
    hold_s     = ALLOW_HOLD && (bus_in == prev_r);
    capture_s  = sample_en && !resync;
  end

  // next-state and fault decode; resync overrides any coincident sample
  always_comb begin
    state_n_s     = state_r;
    match_cnt_n_s = match_cnt_r;
    fault_s       = 1'b0;
    if (resync) begin
      state_n_s     = UNLOCKED;
      match_cnt_n_s = {MW{1'b0}};
    end else if (sample_en) begin
      case (state_r)
        UNLOCKED: begin
          state_n_s     = ACQUIRE;
          match_cnt_n_s = {MW{1'b0}};
        end
        ACQUIRE: begin
          if (match_s) begin
            match_cnt_n_s = match_cnt_r + MW'(1);
            if ((match_cnt_r + MW'(1)) == MW'(LOCK_CNT)) begin
              state_n_s = LOCKED;
            end else begin
              state_n_s = ACQUIRE;
            end
          end else if (hold_s) begin
            state_n_s = ACQUIRE;
          end else begin
            match_cnt_n_s = {MW{1'b0}};
            state_n_s     = ACQUIRE;
          end
        end
        LOCKED: begin
          if (match_s || hold_s) begin
            state_n_s = LOCKED;
          end else begin
            state_n_s = FAULT;
            fault_s   = 1'b1;
          end
        end
        FAULT: begin
          state_n_s     = ACQUIRE;
          match_cnt_n_s = {MW{1'b0}};
        end
        default: begin
          state_n_s     = UNLOCKED;
          match_cnt_n_s = {MW{1'b0}};
        end
      endcase
    end else begin
      state_n_s = state_r;
    end
  end

  // state, match counter and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= UNLOCKED;
      match_cnt_r <= {MW{1'b0}};
      locked_r    <= 1'b0;
      err_pulse_r <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      match_cnt_r <= match_cnt_n_s;
      locked_r    <= (state_n_s == LOCKED);
      err_pulse_r <= fault_s;
    end
  end

  // sample capture, taken in every state unless resync cancels it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r     <= {WIDTH{1'b0}};
      last_val_r <= {WIDTH{1'b0}};
    end else if (capture_s) begin
      prev_r     <= bus_in;
      last_val_r <= bus_in;
    end else begin
      prev_r     <= prev_r;
      last_val_r <= last_val_r;
    end
  end

  sat_counter #(
    .W   (CNT_WIDTH),
    .MAX (ERR_CNT_MAX)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fault_s),
    .clr   (clr_err),
    .count (err_count)
  );

  assign locked    = locked_r;
  assign err_pulse = err_pulse_r;
  assign last_val  = last_val_r;

endmodule

// File: tb/tb_count_stream_checker.sv
// Directed bench: one checker with holds allowed, one with holds treated as mismatches, same stimulus.
module tb_count_stream_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] bus_in = 8'd0;
  logic       sample_en = 1'b0;
  logic       resync = 1'b0;
  logic       clr_err = 1'b0;

  logic       locked_h, err_pulse_h;
  logic [7:0] err_count_h, last_val_h;
  logic       locked_n, err_pulse_n;
  logic [7:0] err_count_n, last_val_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  count_stream_checker #(.WIDTH(8), .LOCK_CNT(4), .ALLOW_HOLD(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .sample_en(sample_en),
    .resync(resync), .clr_err(clr_err), .locked(locked_h),
    .err_pulse(err_pulse_h), .err_count(err_count_h), .last_val(last_val_h)
  );

  count_stream_checker #(.WIDTH(8), .LOCK_CNT(4), .ALLOW_HOLD(1'b0)) dut_nohold (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .sample_en(sample_en),
    .resync(resync), .clr_err(clr_err), .locked(locked_n),
    .err_pulse(err_pulse_n), .err_count(err_count_n), .last_val(last_val_n)
  );

  // one strobe; returns at the following falling edge with outputs settled
  task automatic strobe(input logic [7:0] v);
    @(negedge clk);
    bus_in = v;
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
  endtask

  task automatic do_resync();
    @(negedge clk);
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (locked_h !== 1'b0 || err_pulse_h !== 1'b0 || err_count_h !== 8'd0 || last_val_h !== 8'd0) begin
      errors++;
      $display("FAIL reset: locked=%b pulse=%b cnt=%0d last=%0d, required all 0", locked_h, err_pulse_h, err_count_h, last_val_h);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lock();
    for (int v = 10; v <= 13; v++) begin
      strobe(8'(v));
      checks++;
      if (locked_h !== 1'b0) begin
        errors++;
        $display("FAIL lock_early v=%0d: locked=%b required 0", v, locked_h);
      end
    end
    strobe(8'd14);
    checks++;
    if (locked_h !== 1'b1 || err_count_h !== 8'd0 || last_val_h !== 8'd14) begin
      errors++;
      $display("FAIL lock: locked=%b cnt=%0d last=%0d, required 1 0 14", locked_h, err_count_h, last_val_h);
    end
  endtask

  task automatic test_wrap();
    do_resync();
    for (int v = 248; v <= 252; v++) strobe(8'(v));
    checks++;
    if (locked_h !== 1'b1) begin
      errors++;
      $display("FAIL wrap_lock: locked=%b required 1", locked_h);
    end
    for (int i = 0; i < 5; i++) begin
      strobe(8'(253 + i));
      checks++;
      if (locked_h !== 1'b1 || err_pulse_h !== 1'b0) begin
        errors++;
        $display("FAIL wrap step %0d: locked=%b pulse=%b, required 1 0", i, locked_h, err_pulse_h);
      end
    end
    checks++;
    if (last_val_h !== 8'd1 || err_count_h !== 8'd0) begin
      errors++;
      $display("FAIL wrap_end: last=%0d cnt=%0d, required 1 0", last_val_h, err_count_h);
    end
  endtask

  task automatic test_fault();
    do_resync();
    for (int v = 16; v <= 20; v++) strobe(8'(v));
    strobe(8'd22);
    checks++;
    if (err_pulse_h !== 1'b1 || err_count_h !== 8'd1 || locked_h !== 1'b0) begin
      errors++;
      $display("FAIL fault: pulse=%b cnt=%0d locked=%b, required 1 1 0", err_pulse_h, err_count_h, locked_h);
    end
    @(negedge clk);
    checks++;
    if (err_pulse_h !== 1'b0) begin
      errors++;
      $display("FAIL fault_pulse_width: pulse=%b required 0", err_pulse_h);
    end
    for (int v = 23; v <= 26; v++) strobe(8'(v));
    checks++;
    if (locked_h !== 1'b0 || err_count_h !== 8'd1) begin
      errors++;
      $display("FAIL relock_early: locked=%b cnt=%0d, required 0 1", locked_h, err_count_h);
    end
    strobe(8'd27);
    checks++;
    if (locked_h !== 1'b1 || err_count_h !== 8'd1) begin
      errors++;
      $display("FAIL relock: locked=%b cnt=%0d, required 1 1", locked_h, err_count_h);
    end
  endtask

  task automatic test_hold();
    do_resync();
    do_clr();
    for (int v = 1; v <= 5; v++) strobe(8'(v));
    checks++;
    if (locked_h !== 1'b1 || locked_n !== 1'b1) begin
      errors++;
      $display("FAIL hold_lock: locked=%b/%b required 1/1", locked_h, locked_n);
    end
    strobe(8'd5);
    checks++;
    if (err_pulse_h !== 1'b0 || err_pulse_n !== 1'b1) begin
      errors++;
      $display("FAIL hold_pulse: pulse=%b/%b required 0/1", err_pulse_h, err_pulse_n);
    end
    strobe(8'd5);
    strobe(8'd6);
    checks++;
    if (locked_h !== 1'b1 || err_count_h !== 8'd0) begin
      errors++;
      $display("FAIL hold_allowed: locked=%b cnt=%0d, required 1 0", locked_h, err_count_h);
    end
    checks++;
    if (locked_n !== 1'b0 || err_count_n !== 8'd1) begin
      errors++;
      $display("FAIL hold_disallowed: locked=%b cnt=%0d, required 0 1", locked_n, err_count_n);
    end
  endtask

  task automatic test_resync();
    @(negedge clk);
    bus_in = 8'd99;
    sample_en = 1'b1;
    resync = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    resync = 1'b0;
    checks++;
    if (locked_h !== 1'b0 || last_val_h !== 8'd6) begin
      errors++;
      $display("FAIL resync: locked=%b last=%0d, required 0 6", locked_h, last_val_h);
    end
    for (int v = 40; v <= 43; v++) strobe(8'(v));
    checks++;
    if (locked_h !== 1'b0) begin
      errors++;
      $display("FAIL resync_early: locked=%b required 0", locked_h);
    end
    strobe(8'd44);
    checks++;
    if (locked_h !== 1'b1 || locked_n !== 1'b1 || last_val_h !== 8'd44) begin
      errors++;
      $display("FAIL resync_relock: locked=%b/%b last=%0d, required 1/1 44", locked_h, locked_n, last_val_h);
    end
  endtask

  task automatic test_saturate();
    logic [7:0] base;
    do_resync();
    do_clr();
    base = 8'd0;
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 5; k++) strobe(base + 8'(k));
      strobe(base + 8'd10);
      if (i == 0) begin
        checks++;
        if (err_count_h !== 8'd1) begin
          errors++;
          $display("FAIL sat_first: cnt=%0d required 1", err_count_h);
        end
      end
      base = base + 8'd20;
    end
    checks++;
    if (err_count_h !== 8'd255 || err_count_n !== 8'd255) begin
      errors++;
      $display("FAIL saturate: cnt=%0d/%0d required 255/255", err_count_h, err_count_n);
    end
    for (int v = 100; v <= 104; v++) strobe(8'(v));
    @(negedge clk);
    bus_in = 8'd110;
    sample_en = 1'b1;
    clr_err = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    clr_err = 1'b0;
    checks++;
    if (err_count_h !== 8'd1 || err_pulse_h !== 1'b1) begin
      errors++;
      $display("FAIL clr_with_fault: cnt=%0d pulse=%b, required 1 1", err_count_h, err_pulse_h);
    end
  endtask

  task automatic test_reset_mid();
    do_resync();
    strobe(8'd60);
    strobe(8'd61);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (locked_h !== 1'b0 || err_pulse_h !== 1'b0 || err_count_h !== 8'd0 || last_val_h !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid: locked=%b pulse=%b cnt=%0d last=%0d, required all 0", locked_h, err_pulse_h, err_count_h, last_val_h);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int v = 70; v <= 73; v++) strobe(8'(v));
    checks++;
    if (locked_h !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_early: locked=%b required 0", locked_h);
    end
    strobe(8'd74);
    checks++;
    if (locked_h !== 1'b1 || last_val_h !== 8'd74) begin
      errors++;
      $display("FAIL post_reset_lock: locked=%b last=%0d, required 1 74", locked_h, last_val_h);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_wrap();
    test_fault();
    test_hold();
    test_resync();
    test_saturate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
